// File: rtl/imem_loader.sv
// Program loader: assembles little-endian 32-bit words from a byte stream and
// writes them to instruction memory at consecutive word addresses from 0.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Start,
  input  logic [ADDR_W:0]   WordCount,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [31:0]       Checksum
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [23:0]         asm_q, asm_d;
  logic                rx_ready_q, rx_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [31:0]         checksum_q, checksum_d;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    count_d     = count_q;
    asm_d       = asm_q;
    rx_ready_d  = rx_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    checksum_d  = checksum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          checksum_d = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          count_d    = WordCount;
          if (WordCount == '0 || WordCount > DEPTH_C) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            rx_ready_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            state_d    = S_RECV;
            rx_ready_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end

      S_RECV: begin
        if (RxValid && rx_ready_q) begin
          if (byte_idx_q == 2'd3) begin
            // Last byte goes straight into the write data, not the assembly register.
            state_d     = S_WRITE;
            rx_ready_d  = 1'b0;
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q;
            mem_wdata_d = {RxData, asm_q};
          end else begin
            case (byte_idx_q)
              2'd0:    asm_d[7:0]   = RxData;
              2'd1:    asm_d[15:8]  = RxData;
              default: asm_d[23:16] = RxData;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        checksum_d = checksum_q + mem_wdata_q;
        if ({1'b0, word_idx_q} == count_q - 1'b1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d    = S_RECV;
          word_idx_d = word_idx_q + 1'b1;
          byte_idx_d = '0;
          rx_ready_d = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        rx_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      count_q     <= '0;
      asm_q       <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      checksum_q  <= checksum_d;
    end
  end

  assign RxReady  = rx_ready_q;
  assign MemWE    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign Checksum = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives byte streams and compares the captured memory
// writes and checksum against words rebuilt directly from the byte list.
module tb_imem_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              Start;
  logic [ADDR_W:0]   WordCount;
  logic [7:0]        RxData;
  logic              RxValid;
  logic              RxReady;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [31:0]       Checksum;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W+31:0] wr_q[$];   // captured {addr, data} of every write
  logic [7:0]         bq[$];     // bytes of the current load

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .WordCount(WordCount),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .Busy(Busy), .Done(Done), .Error(Error), .Checksum(Checksum)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (MemWE === 1'b1) wr_q.push_back({MemAddr, MemWData});

  function automatic logic [31:0] exp_word(input int i);
    return {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
  endfunction

  function automatic logic [31:0] exp_sum(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += exp_word(i);
    return s;
  endfunction

  task automatic do_start(input int n);
    Start = 1'b1;
    WordCount = (ADDR_W+1)'(n);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    RxData = b;
    RxValid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (RxReady === 1'b1) begin ok = 1; break; end
      @(negedge CLK);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rx_handshake: RxReady=%b, want 1 within 20 cycles", RxReady); end
    @(negedge CLK);
    RxValid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i < last; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge CLK);
      send_byte(bq[i]);
    end
  endtask

  task automatic wait_end();
    bit ok = 0;
    for (int t = 0; t < 40; t++) begin
      if (Done === 1'b1 || Error === 1'b1) begin ok = 1; break; end
      @(negedge CLK);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL load_end: Done=%b Error=%b, want end within 40 cycles", Done, Error); end
  endtask

  task automatic fill_random(input int n);
    bq.delete();
    for (int i = 0; i < 4*n; i++) bq.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    RESET = 1'b1; Start = 1'b0; WordCount = '0; RxData = '0; RxValid = 1'b0;
    @(negedge CLK);
    tests++;
    if ({RxReady, MemWE, MemAddr, MemWData, Busy, Done, Error, Checksum} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%0d d=%h busy=%b done=%b err=%b sum=%h, want all 0",
               RxReady, MemWE, MemAddr, MemWData, Busy, Done, Error, Checksum);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    bq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
    wr_q.delete();
    do_start(2);
    send_range(0, 8, 0);
    wait_end();
    tests++;
    if (wr_q.size() != 2) begin fails++; $display("FAIL basic_nwrites: got %0d, want 2", wr_q.size()); end
    else begin
      tests++;
      if (wr_q[0] !== {6'd0, 32'h00500013}) begin fails++; $display("FAIL basic_w0: got %h, want %h", wr_q[0], {6'd0, 32'h00500013}); end
      tests++;
      if (wr_q[1] !== {6'd1, 32'h00108093}) begin fails++; $display("FAIL basic_w1: got %h, want %h", wr_q[1], {6'd1, 32'h00108093}); end
    end
    tests++;
    if ({Done, Busy, Error, Checksum} !== {3'b100, 32'h006080A6}) begin
      fails++; $display("FAIL basic_status: got done=%b busy=%b err=%b sum=%h, want 1 0 0 006080a6", Done, Busy, Error, Checksum);
    end
  endtask

  task automatic test_gaps();
    wr_q.delete();
    do_start(2);
    for (int i = 0; i < 8; i++) begin
      repeat (3) begin
        @(negedge CLK);
        if (Busy === 1'b1 && MemWE !== 1'b1) begin
          tests++;
          if (RxReady !== 1'b1) begin fails++; $display("FAIL gaps_rxready: got %b, want 1 (byte %0d)", RxReady, i); end
        end
      end
      send_byte(bq[i]);
    end
    wait_end();
    repeat (5) @(negedge CLK);
    tests++;
    if (wr_q.size() != 2) begin fails++; $display("FAIL gaps_nwrites: got %0d, want 2", wr_q.size()); end
    else begin
      tests++;
      if (wr_q[0] !== {6'd0, 32'h00500013} || wr_q[1] !== {6'd1, 32'h00108093}) begin
        fails++; $display("FAIL gaps_writes: got %h %h, want %h %h", wr_q[0], wr_q[1], {6'd0, 32'h00500013}, {6'd1, 32'h00108093});
      end
    end
    tests++;
    if (Checksum !== 32'h006080A6 || Done !== 1'b1) begin
      fails++; $display("FAIL gaps_sum: got sum=%h done=%b, want 006080a6 1", Checksum, Done);
    end
  endtask

  task automatic test_error();
    wr_q.delete();
    do_start(0);
    tests++;
    if ({Error, RxReady, Busy, Done} !== 4'b1000) begin
      fails++; $display("FAIL err_zero: got err=%b rdy=%b busy=%b done=%b, want 1 0 0 0", Error, RxReady, Busy, Done);
    end
    do_start(DEPTH + 1);
    RxValid = 1'b1; RxData = 8'hAA;
    repeat (3) @(negedge CLK);
    RxValid = 1'b0;
    tests++;
    if ({Error, RxReady, Busy} !== 3'b100) begin
      fails++; $display("FAIL err_over: got err=%b rdy=%b busy=%b, want 1 0 0", Error, RxReady, Busy);
    end
    tests++;
    if (wr_q.size() != 0) begin fails++; $display("FAIL err_nowrite: got %0d writes, want 0", wr_q.size()); end
    fill_random(1);
    do_start(1);
    tests++;
    if ({Error, Busy} !== 2'b01) begin fails++; $display("FAIL err_clear: got err=%b busy=%b, want 0 1", Error, Busy); end
    send_range(0, 4, 2);
    wait_end();
    tests++;
    if (wr_q.size() != 1 || wr_q[0] !== {6'd0, exp_word(0)} || Checksum !== exp_word(0)) begin
      fails++; $display("FAIL err_after_load: got n=%0d sum=%h, want 1 write of %h", wr_q.size(), Checksum, exp_word(0));
    end
  endtask

  task automatic test_full();
    int bad = 0;
    bq.delete();
    for (int n = 0; n < 4*DEPTH; n++) bq.push_back(8'(n));
    wr_q.delete();
    do_start(DEPTH);
    send_range(0, 4*DEPTH, 0);
    wait_end();
    repeat (10) @(negedge CLK);
    tests++;
    if (wr_q.size() != DEPTH) begin fails++; $display("FAIL full_nwrites: got %0d, want %0d", wr_q.size(), DEPTH); end
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        tests++;
        if (wr_q[i] !== {6'(i), exp_word(i)}) begin
          fails++; $display("FAIL full_write%0d: got %h, want %h", i, wr_q[i], {6'(i), exp_word(i)});
        end
      end
      tests++;
      if (wr_q[DEPTH-1][31:0] !== 32'hFFFEFDFC) begin fails++; $display("FAIL full_last: got %h, want fffefdfc", wr_q[DEPTH-1][31:0]); end
    end
    tests++;
    if (Done !== 1'b1 || Checksum !== exp_sum(DEPTH)) begin
      fails++; $display("FAIL full_status: got done=%b sum=%h, want 1 %h", Done, Checksum, exp_sum(DEPTH));
    end
  endtask

  task automatic test_start_in_recv();
    fill_random(3);
    wr_q.delete();
    do_start(3);
    send_range(0, 2, 1);
    do_start(1);
    send_range(2, 12, 1);
    wait_end();
    tests++;
    if (wr_q.size() != 3) begin fails++; $display("FAIL recv_start_nwrites: got %0d, want 3", wr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++;
      if (wr_q[i] !== {6'(i), exp_word(i)}) begin fails++; $display("FAIL recv_start_w%0d: got %h, want %h", i, wr_q[i], {6'(i), exp_word(i)}); end
    end
    tests++;
    if (Checksum !== exp_sum(3)) begin fails++; $display("FAIL recv_start_sum: got %h, want %h", Checksum, exp_sum(3)); end
    fill_random(1);
    wr_q.delete();
    do_start(1);
    tests++;
    if ({Done, Busy, Checksum} !== {2'b01, 32'h0}) begin
      fails++; $display("FAIL restart_clear: got done=%b busy=%b sum=%h, want 0 1 0", Done, Busy, Checksum);
    end
    send_range(0, 4, 0);
    wait_end();
    tests++;
    if (wr_q.size() != 1 || wr_q[0] !== {6'd0, exp_word(0)} || Checksum !== exp_word(0)) begin
      fails++; $display("FAIL restart_load: got n=%0d sum=%h, want 1 write at 0 of %h", wr_q.size(), Checksum, exp_word(0));
    end
  endtask

  task automatic test_reset_mid();
    fill_random(3);
    wr_q.delete();
    do_start(3);
    send_range(0, 6, 0);
    #2 RESET = 1'b1;
    #1;
    tests++;
    if ({RxReady, MemWE, MemAddr, MemWData, Busy, Done, Error, Checksum} !== '0) begin
      fails++; $display("FAIL reset_async: got rdy=%b we=%b a=%0d d=%h busy=%b sum=%h, want all 0",
                        RxReady, MemWE, MemAddr, MemWData, Busy, Checksum);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if (wr_q.size() != 1) begin fails++; $display("FAIL reset_nowrite: got %0d writes, want 1", wr_q.size()); end
    fill_random(3);
    wr_q.delete();
    do_start(3);
    send_range(0, 12, 1);
    wait_end();
    tests++;
    if (wr_q.size() != 3 || wr_q[0] !== {6'd0, exp_word(0)} || wr_q[2] !== {6'd2, exp_word(2)}) begin
      fails++; $display("FAIL reset_reload: got n=%0d first=%h, want 3 from %h", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : '0, {6'd0, exp_word(0)});
    end
    tests++;
    if (Checksum !== exp_sum(3)) begin fails++; $display("FAIL reset_reload_sum: got %h, want %h", Checksum, exp_sum(3)); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 8);
      fill_random(n);
      wr_q.delete();
      do_start(n);
      send_range(0, 4*n, 3);
      wait_end();
      tests++;
      if (wr_q.size() != n) begin fails++; $display("FAIL rand%0d_nwrites: got %0d, want %0d", r, wr_q.size(), n); end
      else for (int i = 0; i < n; i++) begin
        tests++;
        if (wr_q[i] !== {6'(i), exp_word(i)}) begin fails++; $display("FAIL rand%0d_w%0d: got %h, want %h", r, i, wr_q[i], {6'(i), exp_word(i)}); end
      end
      tests++;
      if (Checksum !== exp_sum(n) || Done !== 1'b1) begin
        fails++; $display("FAIL rand%0d_sum: got %h done=%b, want %h 1", r, Checksum, Done, exp_sum(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_error();
    test_full();
    test_start_in_recv();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write-side counterpart of the instruction memory.
- Receives a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, and issues one memory write per word at consecutive word addresses from 0.
- Sits between the host/UART byte source and the instruction memory write port. Busy holds the CPU core in reset while a load is in progress.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory.
- ADDR_W, 6, word-address width; DEPTH must be ≤ 2^ADDR_W.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  reset, asynchronous, active-high.
- Start  input  1  one-cycle pulse; starts a load.
- WordCount  input  ADDR_W+1  number of words to load; sampled on an accepted Start.
- RxData  input  8  incoming byte.
- RxValid  input  1  RxData valid.
- RxReady  output  1  loader can accept a byte.
- MemWE  output  1  memory write enable.
- MemAddr  output  ADDR_W  memory word address.
- MemWData  output  32  memory write data.
- Busy  output  1  load in progress (states RECV, WRITE).
- Done  output  1  load completed; held until the next accepted Start.
- Error  output  1  illegal WordCount; held until the next accepted Start.
- Checksum  output  32  running sum mod 2^32 of all written words.

Behaviour:
- States: IDLE, RECV, WRITE, DONE, ERROR. All state and outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-load):
  - state=IDLE, RxReady=0, MemWE=0, MemAddr=0, MemWData=0, Busy=0, Done=0, Error=0, Checksum=0.
  - Internal byte index, word index and latched count all go to 0.
  - A partially assembled word is discarded. Memory contents are not touched.
- Start is accepted in IDLE, DONE and ERROR only; it is ignored in RECV and WRITE.
- On an accepted Start:
  - Clear Done, Error, Checksum, byte index and word index.
  - Latch WordCount.
  - If WordCount==0 or WordCount>DEPTH, go to ERROR; otherwise go to RECV.
- RECV:
  - RxReady=1.
  - A byte transfers on a CLK edge where RxValid && RxReady.
  - Byte index k (0..3) is written to bits [8k+7:8k] of the assembly register; first byte lands in bits [7:0].
  - RxValid=0 cycles stall with no state change.
  - The edge accepting byte 3 moves to WRITE.
- WRITE (exactly one cycle):
  - RxReady=0, MemWE=1, MemAddr=word index, MemWData=assembled word.
  - Checksum += word, updated at the end of this cycle.
  - If word index == latched count−1, go to DONE. Otherwise word index +1, byte index 0, back to RECV.
- Throughput: 4 accepted bytes plus 1 write cycle per word, i.e. 5 cycles minimum per word.
- MemWE is asserted only in WRITE; MemAddr and MemWData hold their last values elsewhere.
- DONE: Done=1, RxReady=0. ERROR: Error=1, RxReady=0. Each holds until an accepted Start or reset.
- Busy=1 exactly in RECV and WRITE.
- Word index never wraps: the maximum address written is latched count−1 ≤ DEPTH−1.
- Bytes presented while RxReady=0 are not consumed; the source must hold them.

Test Plan:
- Reset, Start with WordCount=2, bytes 0x13,0x00,0x50,0x00, 0x93,0x80,0x10,0x00, RxValid continuous:
  - MemWE pulses with addr 0 data 0x00500013, then addr 1 data 0x00108093.
  - Done=1, Checksum=0x006080A6, Busy low after the second write.
- Same 2-word load with RxValid=0 for 3 cycles between every byte:
  - Identical writes and checksum; RxReady stays high throughout RECV.
  - No extra MemWE pulses.
- Start with WordCount=0, then Start with WordCount=65 (DEPTH=64):
  - Error=1 next cycle, RxReady=0, MemWE never asserted.
  - A following Start with WordCount=1 clears Error.
- WordCount=64 with 256 bytes, byte n=n&0xFF:
  - 64 writes, addresses 0..63 in order; last data 0xFFFEFDFC.
  - No write to address 0 after 63; Done=1.
- Start pulsed during RECV after 2 bytes:
  - Ignored; load continues and completes with the original count.
  - Start in DONE restarts from address 0.
- RESET asserted mid-word during a 3-word load:
  - Outputs go to reset values immediately, with no MemWE afterwards.
  - Fresh Start loads correctly from address 0 with Checksum starting at 0.
